// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the memory stage:
//   - writeback buffer layout (bit positions and total width)
//   - memory stage state encoding
//   - pack_wb(): assembles a writeback buffer word from its fields
// ---------------------------------------------------------------------------
package cpu_pkg;

   // Writeback buffer layout, MSB first:
   // RegWrite | MemToReg | result[63:0] | loaded data[63:0] | rd[4:0]
   localparam int WB_BUF_W = 135;
   localparam int RW_BIT   = 134;
   localparam int M2R_BIT  = 133;
   localparam int RES_HI   = 132;
   localparam int RES_LO   = 69;
   localparam int LD_HI    = 68;
   localparam int LD_LO    = 5;
   localparam int RD_HI    = 4;
   localparam int RD_LO    = 0;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_WAIT_MEM = 1'b1
   } mem_state_e;

   function automatic logic [WB_BUF_W-1:0] pack_wb(
      input logic        rw,
      input logic        m2r,
      input logic [63:0] res,
      input logic [63:0] ld,
      input logic [4:0]  rd
   );
      logic [WB_BUF_W-1:0] w;
      w                 = '0;
      w[RW_BIT]         = rw;
      w[M2R_BIT]        = m2r;
      w[RES_HI:RES_LO]  = res;
      w[LD_HI:LD_LO]    = ld;
      w[RD_HI:RD_LO]    = rd;
      return w;
   endfunction

endpackage

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
// Pipeline memory stage: passes ALU results to the writeback buffer and runs
// load/store accesses against a ready-strobed data memory, stalling the
// upstream pipeline while an access is outstanding.
//
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that wait more
// than TIMEOUT cycles (adds the mem_err port and an 8-bit wait counter).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ex_valid            execute-stage operation valid
//   ex_result           ALU result, also the memory address
//   ex_store_data       store write data
//   ex_rd               destination register
//   ex_mem_read/write   load / store (both set = store)
//   ex_mem_to_reg       writeback selects loaded data
//   ex_reg_write        writeback commits to the register file
//   stall               upstream hold request
//   dmem_req/we/addr/wdata  data memory request
//   dmem_ready, dmem_rdata  data memory completion and read data
//   outBuf              writeback buffer (layout in cpu_pkg)
//   mem_err             one-cycle timeout abort pulse (MEM_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module memory_stage
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ex_valid,
   input  logic [63:0]         ex_result,
   input  logic [63:0]         ex_store_data,
   input  logic [4:0]          ex_rd,
   input  logic                ex_mem_read,
   input  logic                ex_mem_write,
   input  logic                ex_mem_to_reg,
   input  logic                ex_reg_write,
   output logic                stall,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [63:0]         dmem_addr,
   output logic [63:0]         dmem_wdata,
   input  logic                dmem_ready,
   input  logic [63:0]         dmem_rdata,
   output logic [WB_BUF_W-1:0] outBuf
`ifdef MEM_TIMEOUT_EN
   ,
   output logic                mem_err
`endif
);

   // TIMEOUT must fit the 8-bit wait counter and be non-zero.
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("memory_stage: TIMEOUT out of range 1..255");
   end

   mem_state_e          state_q, state_d;
   logic                req_q,   req_d;
   logic                we_q,    we_d;
   logic [63:0]         addr_q,  addr_d;
   logic [63:0]         wdata_q, wdata_d;
   logic [WB_BUF_W-1:0] buf_q,   buf_d;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
`endif

   logic is_mem;
   logic is_wr;
   logic issue;

   assign is_mem = ex_mem_read | ex_mem_write;
   assign is_wr  = ex_mem_write;   // read+write together is treated as a store

   // Reset is folded in so the combinational request path is also quiet while
   // rst_n is low, regardless of what the execute stage presents.
   assign issue  = rst_n && (state_q == S_IDLE) && ex_valid && is_mem;

   // ------------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      // Default is a bubble: keep the payload, never re-commit RegWrite.
      buf_d          = buf_q;
      buf_d[RW_BIT]  = 1'b0;
      stall      = 1'b0;
      dmem_req   = req_q;
      dmem_we    = we_q;
      dmem_addr  = addr_q;
      dmem_wdata = wdata_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = 1'b0;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (issue) begin
               dmem_req   = 1'b1;
               dmem_we    = is_wr;
               dmem_addr  = ex_result;
               dmem_wdata = ex_store_data;
               if (dmem_ready) begin
                  // Memory answered in the request cycle: no wait state.
                  buf_d = pack_wb(ex_reg_write, ex_mem_to_reg, ex_result,
                                  is_wr ? 64'd0 : dmem_rdata, ex_rd);
               end else begin
                  stall   = 1'b1;
                  state_d = S_WAIT_MEM;
                  req_d   = 1'b1;
                  we_d    = is_wr;
                  addr_d  = ex_result;
                  wdata_d = ex_store_data;
`ifdef MEM_TIMEOUT_EN
                  cnt_d   = 8'd0;
`endif
               end
            end else if (ex_valid && !is_mem) begin
               buf_d = pack_wb(ex_reg_write, ex_mem_to_reg, ex_result,
                               64'd0, ex_rd);
            end
         end

         S_WAIT_MEM: begin
            // Execute inputs are held by the stall, so rd/result/flags are
            // taken straight from them on completion.
            stall = 1'b1;
            if (dmem_ready) begin
               stall   = 1'b0;
               state_d = S_IDLE;
               req_d   = 1'b0;
               buf_d   = pack_wb(ex_reg_write, ex_mem_to_reg, ex_result,
                                 we_q ? 64'd0 : dmem_rdata, ex_rd);
            end else begin
`ifdef MEM_TIMEOUT_EN
               cnt_d = cnt_q + 8'd1;
               // Counter reaches TIMEOUT at this edge: abort. The request
               // drops and mem_err pulses in the following cycle.
               if (cnt_q + 8'd1 == TO_CNT) begin
                  state_d = S_IDLE;
                  req_d   = 1'b0;
                  err_d   = 1'b1;
               end
`endif
            end
         end

         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign mem_err = err_q;
`endif

   assign outBuf = buf_q;

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
// Random operation stream (ALU ops, bubbles, loads/stores with random memory
// latency) checked against a transaction-level model of the writeback buffer
// and of the memory request handshake. Directed cases cover the ALU op, the
// 3-cycle load, the single-cycle store, reset during a wait and, with
// MEM_TIMEOUT_EN, the timeout abort.
// ---------------------------------------------------------------------------
module tb_memory_stage;

   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ex_valid;
   logic [63:0]  ex_result;
   logic [63:0]  ex_store_data;
   logic [4:0]   ex_rd;
   logic         ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
   logic         stall;
   logic         dmem_req, dmem_we;
   logic [63:0]  dmem_addr, dmem_wdata;
   logic         dmem_ready;
   logic [63:0]  dmem_rdata;
   logic [134:0] outBuf;
`ifdef MEM_TIMEOUT_EN
   logic         mem_err;
`endif

   int checks = 0;
   int errors = 0;

   // Model of what the writeback buffer must hold.
   logic [134:0] exp_buf;

   memory_stage #(.TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .ex_result     (ex_result),
      .ex_store_data (ex_store_data),
      .ex_rd         (ex_rd),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_mem_to_reg (ex_mem_to_reg),
      .ex_reg_write  (ex_reg_write),
      .stall         (stall),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_ready    (dmem_ready),
      .dmem_rdata    (dmem_rdata),
      .outBuf        (outBuf)
`ifdef MEM_TIMEOUT_EN
      ,
      .mem_err       (mem_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [134:0] act,
                        input logic [134:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   // Advance past the next rising edge; inputs change and registered outputs
   // are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      ex_valid      = 1'b0;
      ex_result     = r64();
      ex_rd         = 5'($urandom);
      ex_mem_read   = 1'($urandom);
      ex_mem_write  = 1'($urandom);
      ex_reg_write  = 1'($urandom);
      ex_mem_to_reg = 1'($urandom);
      dmem_ready    = 1'($urandom);   // stray ready must be ignored
      dmem_rdata    = r64();
      #1;
      check("bubble_req", 135'(dmem_req), 135'(0));
      check("bubble_stall", 135'(stall), 135'(0));
      tick();
      exp_buf[134] = 1'b0;
      check("bubble_buf", outBuf, exp_buf);
      dmem_ready = 1'b0;
   endtask

   task automatic alu_op(input logic [63:0] res, input logic [4:0] rd,
                         input logic rw, input logic m2r);
      ex_valid      = 1'b1;
      ex_result     = res;
      ex_store_data = r64();
      ex_rd         = rd;
      ex_mem_read   = 1'b0;
      ex_mem_write  = 1'b0;
      ex_reg_write  = rw;
      ex_mem_to_reg = m2r;
      dmem_ready    = 1'($urandom);
      dmem_rdata    = r64();
      #1;
      check("alu_stall", 135'(stall), 135'(0));
      check("alu_req", 135'(dmem_req), 135'(0));
      tick();
      exp_buf = {rw, m2r, res, 64'd0, rd};
      check("alu_buf", outBuf, exp_buf);
      dmem_ready = 1'b0;
   endtask

   // Memory op whose ready arrives dly cycles after the request cycle.
   task automatic mem_op(input logic rd_en, input logic wr_en,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] rdat, input logic [4:0] rd,
                         input logic rw, input logic m2r, input int dly);
      logic wr;
      wr            = wr_en;
      ex_valid      = 1'b1;
      ex_result     = addr;
      ex_store_data = wd;
      ex_rd         = rd;
      ex_mem_read   = rd_en;
      ex_mem_write  = wr_en;
      ex_reg_write  = rw;
      ex_mem_to_reg = m2r;
      for (int k = 0; k <= dly; k++) begin
         dmem_ready = (k == dly);
         dmem_rdata = (k == dly) ? rdat : r64();
         #1;
         check("mem_req", 135'(dmem_req), 135'(1));
         check("mem_we", 135'(dmem_we), 135'(wr));
         check("mem_addr", 135'(dmem_addr), 135'(addr));
         check("mem_wdata", 135'(dmem_wdata), 135'(wd));
         check("mem_stall", 135'(stall), 135'(k < dly));
         tick();
         if (k < dly) begin
            exp_buf[134] = 1'b0;
            check("mem_wait_buf", outBuf, exp_buf);
         end
      end
      exp_buf = {rw, m2r, addr, wr ? 64'd0 : rdat, rd};
      check("mem_done_buf", outBuf, exp_buf);
      dmem_ready = 1'b0;
      ex_valid   = 1'b0;
   endtask

   task automatic random_op();
      int   kind;
      logic rr, ww;
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
         alu_op(r64(), 5'($urandom), 1'($urandom), 1'($urandom));
      end else if (kind == 1) begin
         bubble();
      end else begin
         rr = 1'($urandom);
         ww = 1'($urandom);
         if (!rr && !ww) rr = 1'b1;
         // Stores never carry RegWrite.
         mem_op(rr, ww, r64(), r64(), r64(), 5'($urandom),
                ww ? 1'b0 : 1'($urandom), rr & ~ww,
                int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      ex_valid      = 1'b0;
      ex_result     = '0;
      ex_store_data = '0;
      ex_rd         = '0;
      ex_mem_read   = 1'b0;
      ex_mem_write  = 1'b0;
      ex_mem_to_reg = 1'b0;
      ex_reg_write  = 1'b0;
      dmem_ready    = 1'b0;
      dmem_rdata    = '0;
      exp_buf       = '0;

      repeat (2) tick();
      check("rst_buf", outBuf, 135'(0));
      check("rst_req", 135'(dmem_req), 135'(0));
      check("rst_addr", 135'(dmem_addr), 135'(0));
      check("rst_wdata", 135'(dmem_wdata), 135'(0));
      check("rst_we", 135'(dmem_we), 135'(0));
      check("rst_stall", 135'(stall), 135'(0));
`ifdef MEM_TIMEOUT_EN
      check("rst_err", 135'(mem_err), 135'(0));
`endif
      rst_n = 1'b1;

      // ALU op accepted on the first edge after reset release.
      alu_op(64'h10, 5'd3, 1'b1, 1'b0);
      check("alu_exact", outBuf, {1'b1, 1'b0, 64'h10, 64'h0, 5'd3});

      // Load with 3-cycle ready delay: request high for 4 cycles.
      mem_op(1'b1, 1'b0, 64'h100, 64'h0, 64'hDEAD_BEEF, 5'd7, 1'b1, 1'b1, 3);
      check("load_data", 135'(outBuf[68:5]), 135'(64'hDEAD_BEEF));
      check("load_m2r", 135'(outBuf[133]), 135'(1));
      bubble();

      // Store with immediate ready.
      mem_op(1'b0, 1'b1, 64'h8, 64'h55, 64'h0, 5'd2, 1'b0, 1'b0, 0);
      check("store_rw", 135'(outBuf[134]), 135'(0));

      // Both read and write set: must behave as a store.
      mem_op(1'b1, 1'b1, 64'h40, 64'h1234, 64'hFFFF, 5'd9, 1'b0, 1'b0, 1);

      for (int i = 0; i < 80; i++) random_op();

      // Reset in the middle of a wait, then a late ready.
      ex_valid      = 1'b1;
      ex_result     = 64'h200;
      ex_store_data = 64'h0;
      ex_rd         = 5'd5;
      ex_mem_read   = 1'b1;
      ex_mem_write  = 1'b0;
      ex_reg_write  = 1'b1;
      ex_mem_to_reg = 1'b1;
      dmem_ready    = 1'b0;
      tick();
      tick();
      check("pre_rst_stall", 135'(stall), 135'(1));
      #2;
      rst_n    = 1'b0;
      ex_valid = 1'b0;
      #1;
      check("arst_buf", outBuf, 135'(0));
      check("arst_req", 135'(dmem_req), 135'(0));
      check("arst_stall", 135'(stall), 135'(0));
      tick();
      rst_n      = 1'b1;
      dmem_ready = 1'b1;
      dmem_rdata = 64'hBAD;
      #1;
      check("late_rdy_req", 135'(dmem_req), 135'(0));
      tick();
      exp_buf = '0;
      check("late_rdy_buf", outBuf, exp_buf);
      dmem_ready = 1'b0;
      alu_op(64'hABC, 5'd1, 1'b1, 1'b0);

`ifdef MEM_TIMEOUT_EN
      // Load that never gets ready: abort after TO wait cycles.
      ex_valid      = 1'b1;
      ex_result     = 64'h300;
      ex_store_data = 64'h0;
      ex_rd         = 5'd4;
      ex_mem_read   = 1'b1;
      ex_mem_write  = 1'b0;
      ex_reg_write  = 1'b1;
      ex_mem_to_reg = 1'b1;
      dmem_ready    = 1'b0;
      for (int k = 0; k <= TO; k++) begin
         #1;
         check("to_req", 135'(dmem_req), 135'(1));
         check("to_err_low", 135'(mem_err), 135'(0));
         tick();
         exp_buf[134] = 1'b0;
         check("to_buf", outBuf, exp_buf);
      end
      ex_valid = 1'b0;
      #1;
      check("to_err", 135'(mem_err), 135'(1));
      check("to_req_drop", 135'(dmem_req), 135'(0));
      check("to_stall", 135'(stall), 135'(0));
      tick();
      check("to_err_pulse", 135'(mem_err), 135'(0));
      mem_op(1'b1, 1'b0, 64'h310, 64'h0, 64'h77, 5'd6, 1'b1, 1'b1, 1);
`endif

      for (int i = 0; i < 20; i++) random_op();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard bound on simulated time.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum number of data-memory wait cycles before an abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ex_valid  input  1  the execute-stage operation is valid this cycle.
REQ-005 ex_result  input  64  ALU result; doubles as the memory address.
REQ-006 ex_store_data  input  64  store write data.
REQ-007 ex_rd  input  5  destination register.
REQ-008 ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  input  1 each  control bits.
REQ-009 stall  output  1  upstream hold request; execute inputs are held stable while it is high.
REQ-010 dmem_req, dmem_we  output  1 each  memory request and write-enable.
REQ-011 dmem_addr, dmem_wdata  output  64 each  memory address and write data.
REQ-012 dmem_ready  input  1  memory completion strobe.
REQ-013 dmem_rdata  input  64  read data, valid while dmem_ready is high.
REQ-014 outBuf  output  135  writeback buffer: [134] RegWrite, [133] MemToReg, [132:69] result, [68:5] loaded data, [4:0] rd.
REQ-015 mem_err  output  1  one-cycle pulse on a timeout abort (present only with the macro in REQ-032).

Function
REQ-016 State machine: IDLE and WAIT_MEM.
REQ-017 In IDLE, ex_valid with neither mem_read nor mem_write latches the fields into outBuf at the next edge: result, rd, flags, loaded data = 0.
REQ-018 In IDLE, ex_valid with mem_read or mem_write, in the same cycle:
- dmem_req = 1, dmem_addr = ex_result, dmem_we = ex_mem_write, dmem_wdata = ex_store_data;
- stall = 1;
- next state WAIT_MEM.
REQ-019 If dmem_ready is already high in that IDLE cycle, the access completes there: no WAIT_MEM, stall = 0, single-cycle latency.
REQ-020 In WAIT_MEM, dmem_req, addr, we and wdata are held from registered copies, and stall = 1.
REQ-021 On dmem_ready in WAIT_MEM, at the next edge:
- outBuf is written (loaded data = dmem_rdata for a read, 0 for a write);
- state returns to IDLE; stall = 0 combinationally in the ready cycle.
REQ-022 A store writes outBuf with RegWrite = ex_reg_write; the decoder guarantees this is 0.
REQ-023 No ex_valid in IDLE produces a bubble: outBuf[134] = 0, and the other outBuf bits hold their previous values.
REQ-024 While stalled, outBuf[134] is driven 0 every cycle, so the writeback stage never re-commits.
REQ-025 dmem_ready in IDLE without a request is ignored.
REQ-026 dmem_req is never asserted while dmem_ready is high for the previous transaction, except for the single-cycle case in REQ-019.
REQ-027 If mem_read and mem_write are both set, the operation is a write.

Reset
REQ-028 rst_n low asynchronously forces:
- state IDLE;
- outBuf = 0;
- dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0;
- mem_err = 0, wait counter = 0.
REQ-029 Reset during WAIT_MEM abandons the transaction without a writeback; a late dmem_ready is ignored per REQ-025.
REQ-030 The first operation is accepted on the first edge after rst_n rises.

Configuration
REQ-031 An 8-bit wait counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle without dmem_ready.
REQ-032 With MEM_TIMEOUT_EN defined:
- when the counter reaches TIMEOUT and dmem_ready is low, the block drops dmem_req, pulses mem_err for one cycle, writes a bubble (outBuf[134] = 0), and returns to IDLE;
- if dmem_ready and the timeout coincide, ready wins.
REQ-033 With MEM_TIMEOUT_EN undefined, the counter, TIMEOUT logic and mem_err port are absent, and WAIT_MEM waits indefinitely.

Structure
REQ-034 Shared package cpu_pkg holds:
- the outBuf bit-position constants (RW_BIT = 134, M2R_BIT = 133, RES_HI/LO, LD_HI/LO, RD_HI/LO);
- the WB_BUF_W = 135 constant;
- the state enum.
REQ-035 No sub-module is used; the writeback buffer pack function also lives in cpu_pkg.

Verification
REQ-036 ALU op: ex_result = 64'h10, rd = 3, reg_write = 1, no mem -> next edge outBuf = {1, 0, 64'h10, 64'h0, 5'd3}, stall never high.
REQ-037 Load with a 3-cycle ready delay: addr = 64'h100, dmem_rdata = 64'hDEAD_BEEF -> dmem_req high for 4 cycles, stall high until the ready cycle, then outBuf[68:5] = 64'hDEAD_BEEF, MemToReg = 1.
REQ-038 Store with immediate ready: addr = 64'h8, wdata = 64'h55 -> a single-cycle request with we = 1, outBuf[134] = 0, no stall.
REQ-039 MEM_TIMEOUT_EN with TIMEOUT = 4 and no ready -> mem_err pulses after the 4th wait cycle, dmem_req drops, bubble written, next op accepted.
REQ-040 rst_n pulsed low during WAIT_MEM, followed by a late dmem_ready -> outBuf = 0, state IDLE, no write committed.
